rv_imem_line_buffer: RTL and testbench

//  Responder side of the instruction-memory port driven by the fetch stage.

---
 rtl/rv_imem_line_buffer.sv | 101 ++++++++++
 tb/tb_rv_imem_line_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rv_imem_line_buffer.sv
// Instruction-memory responder with a one-line buffer refilled by a burst read.
// Hits return data one cycle after the address; misses stall until the whole line is in.
module rv_imem_line_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_WIDTH-1:0] im_addr_i,
  output logic [31:0]           im_data_o,
  output logic                  im_valid_o,
  input  logic                  inv_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_rvalid_i
);
  localparam int OFFW = $clog2(LINE_WORDS);
  localparam int LSB  = 2 + OFFW;
  localparam int TAGW = ADDR_WIDTH - LSB;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                        state, state_nxt;
  logic [ADDR_WIDTH-1:0]         a_q;
  logic                          line_valid, inv_pend;
  logic [TAGW-1:0]               tag;
  logic [OFFW-1:0]               beat_cnt;
  logic [LINE_WORDS-1:0][31:0]   line;
  logic [31:0]                   data_q;
  logic [TAGW-1:0]               tag_f;
  logic [OFFW-1:0]               idx;
  logic                          hit, last_beat, start_fill, beat;
  logic                          unused_ok;

  assign tag_f      = a_q[ADDR_WIDTH-1:LSB];
  assign idx        = a_q[LSB-1:2];
  assign unused_ok  = ^a_q[1:0];
  assign hit        = line_valid && (tag_f == tag) && (state == IDLE);
  assign beat       = (state == FILL) && mem_rvalid_i;
  assign last_beat  = beat && (beat_cnt == OFFW'(LINE_WORDS - 1));
  assign start_fill = (state == IDLE) && !hit && !inv_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_fill) state_nxt = FILL;
      FILL: if (last_beat)  state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Data holds the last hit word while stalled so the fetch stage sees no glitches.
  always_comb begin
    im_valid_o = hit;
    im_data_o  = hit ? line[idx] : data_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q        <= '0;
      line_valid <= 1'b0;
      tag        <= '0;
      beat_cnt   <= '0;
      inv_pend   <= 1'b0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      data_q     <= '0;
    end else begin
      a_q <= im_addr_i;
      if (hit) data_q <= line[idx];
      if (state == IDLE) begin
        if (inv_i) line_valid <= 1'b0;
        if (start_fill) begin
          mem_req_o  <= 1'b1;
          mem_addr_o <= {tag_f, {LSB{1'b0}}};
          beat_cnt   <= '0;
        end
      end else begin
        if (inv_i) inv_pend <= 1'b1;
        if (beat) beat_cnt <= beat_cnt + 1'b1;
        // A fence.i seen at any point of the refill, including the last beat, discards the line.
        if (last_beat) begin
          mem_req_o  <= 1'b0;
          tag        <= mem_addr_o[ADDR_WIDTH-1:LSB];
          line_valid <= !(inv_pend || inv_i);
          inv_pend   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (beat) line[beat_cnt] <= mem_rdata_i;
  end
endmodule

// File: tb/tb_rv_imem_line_buffer.sv
// Directed bench for rv_imem_line_buffer: refills, back-to-back hits, branches, fence.i, reset.
module tb_rv_imem_line_buffer;
  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] im_addr_i = '0;
  logic [31:0] im_data_o;
  logic        im_valid_o;
  logic        inv_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_rvalid_i = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  rv_imem_line_buffer #(.ADDR_WIDTH(32), .LINE_WORDS(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .im_addr_i(im_addr_i), .im_data_o(im_data_o),
    .im_valid_o(im_valid_o), .inv_i(inv_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic beat(input logic [31:0] d);
    mem_rdata_i = d; mem_rvalid_i = 1'b1;
    step();
    mem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; im_addr_i = 32'h0;
    step();
    n_cmp++; if (mem_req_o !== 1'b0)   begin n_fail++; $display("FAIL rst_req got %b exp 0", mem_req_o); end
    n_cmp++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_maddr got %h exp 0", mem_addr_o); end
    n_cmp++; if (im_valid_o !== 1'b0)  begin n_fail++; $display("FAIL rst_valid got %b exp 0", im_valid_o); end
    n_cmp++; if (im_data_o !== 32'h0)  begin n_fail++; $display("FAIL rst_data got %h exp 0", im_data_o); end
    rst_n_i = 1'b1;
  endtask

  task automatic test_first_fill();
    logic [31:0] d [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    step();
    n_cmp++; if (mem_req_o !== 1'b1)   begin n_fail++; $display("FAIL ff_req got %b exp 1", mem_req_o); end
    n_cmp++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL ff_maddr got %h exp 0", mem_addr_o); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (im_valid_o !== 1'b0) begin n_fail++; $display("FAIL ff_valid_b%0d got %b exp 0", i, im_valid_o); end
      beat(d[i]);
      n_cmp++;
      if (mem_req_o !== (i < 3)) begin n_fail++; $display("FAIL ff_req_b%0d got %b exp %b", i, mem_req_o, i < 3); end
    end
    n_cmp++; if (im_valid_o !== 1'b1)  begin n_fail++; $display("FAIL ff_hit_valid got %b exp 1", im_valid_o); end
    n_cmp++; if (im_data_o !== 32'h11) begin n_fail++; $display("FAIL ff_hit_data got %h exp 11", im_data_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4] = '{32'h4, 32'h8, 32'hC, 32'h0};
    logic [31:0] e [4] = '{32'h22, 32'h33, 32'h44, 32'h11};
    for (int i = 0; i < 4; i++) begin
      im_addr_i = a[i];
      step();
      n_cmp++; if (im_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_valid%0d got %b exp 1", i, im_valid_o); end
      n_cmp++; if (im_data_o !== e[i])  begin n_fail++; $display("FAIL b2b_data%0d got %h exp %h", i, im_data_o, e[i]); end
      n_cmp++; if (mem_req_o !== 1'b0)  begin n_fail++; $display("FAIL b2b_req%0d got %b exp 0", i, mem_req_o); end
    end
  endtask

  task automatic test_gapped_fill();
    im_addr_i = 32'h13;
    step();
    n_cmp++; if (im_valid_o !== 1'b0)  begin n_fail++; $display("FAIL gap_miss got %b exp 0", im_valid_o); end
    n_cmp++; if (im_data_o !== 32'h11) begin n_fail++; $display("FAIL gap_hold got %h exp 11", im_data_o); end
    step();
    n_cmp++; if (mem_req_o !== 1'b1)    begin n_fail++; $display("FAIL gap_req got %b exp 1", mem_req_o); end
    n_cmp++; if (mem_addr_o !== 32'h10) begin n_fail++; $display("FAIL gap_maddr got %h exp 10", mem_addr_o); end
    for (int i = 0; i < 4; i++) begin
      step(); step();
      n_cmp++; if (im_valid_o !== 1'b0) begin n_fail++; $display("FAIL gap_stall%0d got %b exp 0", i, im_valid_o); end
      beat(32'hA0 + i);
    end
    n_cmp++; if (im_valid_o !== 1'b1)  begin n_fail++; $display("FAIL gap_valid got %b exp 1", im_valid_o); end
    n_cmp++; if (im_data_o !== 32'hA0) begin n_fail++; $display("FAIL gap_data got %h exp a0", im_data_o); end
  endtask

  task automatic test_branch_in_fill();
    im_addr_i = 32'h20;
    step(); step();
    n_cmp++; if (mem_addr_o !== 32'h20) begin n_fail++; $display("FAIL br_maddr got %h exp 20", mem_addr_o); end
    beat(32'hB0);
    im_addr_i = 32'h4;
    beat(32'hB1); beat(32'hB2);
    n_cmp++; if (mem_addr_o !== 32'h20) begin n_fail++; $display("FAIL br_maddr_stable got %h exp 20", mem_addr_o); end
    n_cmp++; if (mem_req_o !== 1'b1)    begin n_fail++; $display("FAIL br_req_held got %b exp 1", mem_req_o); end
    beat(32'hB3);
    n_cmp++; if (im_valid_o !== 1'b0)   begin n_fail++; $display("FAIL br_after_valid got %b exp 0", im_valid_o); end
    n_cmp++; if (mem_req_o !== 1'b0)    begin n_fail++; $display("FAIL br_done_req got %b exp 0", mem_req_o); end
    step();
    n_cmp++; if (mem_req_o !== 1'b1)    begin n_fail++; $display("FAIL br_refill_req got %b exp 1", mem_req_o); end
    n_cmp++; if (mem_addr_o !== 32'h0)  begin n_fail++; $display("FAIL br_refill_maddr got %h exp 0", mem_addr_o); end
    beat(32'h11); beat(32'h22); beat(32'h33); beat(32'h44);
    n_cmp++; if (im_valid_o !== 1'b1)   begin n_fail++; $display("FAIL br_valid got %b exp 1", im_valid_o); end
    n_cmp++; if (im_data_o !== 32'h22)  begin n_fail++; $display("FAIL br_data got %h exp 22", im_data_o); end
  endtask

  task automatic test_invalidate();
    im_addr_i = 32'h8;
    step();
    n_cmp++; if (im_data_o !== 32'h33) begin n_fail++; $display("FAIL inv_pre got %h exp 33", im_data_o); end
    inv_i = 1'b1;
    step();
    inv_i = 1'b0;
    n_cmp++; if (im_valid_o !== 1'b0) begin n_fail++; $display("FAIL inv_valid got %b exp 0", im_valid_o); end
    n_cmp++; if (mem_req_o !== 1'b0)  begin n_fail++; $display("FAIL inv_nofill got %b exp 0", mem_req_o); end
    step();
    n_cmp++; if (mem_req_o !== 1'b1)  begin n_fail++; $display("FAIL inv_fill1 got %b exp 1", mem_req_o); end
    beat(32'h55);
    inv_i = 1'b1; beat(32'h66); inv_i = 1'b0;
    beat(32'h77); beat(32'h88);
    n_cmp++; if (im_valid_o !== 1'b0) begin n_fail++; $display("FAIL inv_discard got %b exp 0", im_valid_o); end
    step();
    n_cmp++; if (mem_req_o !== 1'b1)  begin n_fail++; $display("FAIL inv_fill2 got %b exp 1", mem_req_o); end
    n_cmp++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL inv_fill2_maddr got %h exp 0", mem_addr_o); end
    beat(32'h55); beat(32'h66); beat(32'h77);
    inv_i = 1'b1; beat(32'h88); inv_i = 1'b0;
    n_cmp++; if (im_valid_o !== 1'b0) begin n_fail++; $display("FAIL inv_lastbeat got %b exp 0", im_valid_o); end
    step();
    n_cmp++; if (mem_req_o !== 1'b1)  begin n_fail++; $display("FAIL inv_fill3 got %b exp 1", mem_req_o); end
    beat(32'h55); beat(32'h66); beat(32'h77); beat(32'h88);
    n_cmp++; if (im_valid_o !== 1'b1) begin n_fail++; $display("FAIL inv_valid_end got %b exp 1", im_valid_o); end
    n_cmp++; if (im_data_o !== 32'h77) begin n_fail++; $display("FAIL inv_data_end got %h exp 77", im_data_o); end
  endtask

  task automatic test_stray_beat();
    mem_rdata_i = 32'hDEAD; mem_rvalid_i = 1'b1;
    step(); step();
    mem_rvalid_i = 1'b0;
    n_cmp++; if (im_valid_o !== 1'b1)  begin n_fail++; $display("FAIL stray_valid got %b exp 1", im_valid_o); end
    n_cmp++; if (im_data_o !== 32'h77) begin n_fail++; $display("FAIL stray_data got %h exp 77", im_data_o); end
    n_cmp++; if (mem_req_o !== 1'b0)   begin n_fail++; $display("FAIL stray_req got %b exp 0", mem_req_o); end
  endtask

  task automatic test_reset_mid_fill();
    im_addr_i = 32'h30;
    step(); step();
    n_cmp++; if (mem_addr_o !== 32'h30) begin n_fail++; $display("FAIL mr_maddr got %h exp 30", mem_addr_o); end
    beat(32'hC0); beat(32'hC1);
    mem_rdata_i = 32'hC2; mem_rvalid_i = 1'b1;
    #2 rst_n_i = 1'b0;
    #1;
    n_cmp++; if (mem_req_o !== 1'b0)   begin n_fail++; $display("FAIL mr_req_async got %b exp 0", mem_req_o); end
    n_cmp++; if (im_valid_o !== 1'b0)  begin n_fail++; $display("FAIL mr_valid_async got %b exp 0", im_valid_o); end
    n_cmp++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL mr_maddr_async got %h exp 0", mem_addr_o); end
    mem_rvalid_i = 1'b0; im_addr_i = 32'h4;
    step();
    rst_n_i = 1'b1;
    step();
    n_cmp++; if (mem_req_o !== 1'b1)   begin n_fail++; $display("FAIL mr_fill_req got %b exp 1", mem_req_o); end
    n_cmp++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL mr_fill_maddr got %h exp 0", mem_addr_o); end
    beat(32'h11); beat(32'h22); beat(32'h33); beat(32'h44);
    n_cmp++; if (im_valid_o !== 1'b1)  begin n_fail++; $display("FAIL mr_valid got %b exp 1", im_valid_o); end
    n_cmp++; if (im_data_o !== 32'h22) begin n_fail++; $display("FAIL mr_data got %h exp 22", im_data_o); end
  endtask

  initial begin
    test_reset();
    test_first_fill();
    test_back_to_back();
    test_gapped_fill();
    test_branch_in_fill();
    test_invalidate();
    test_stray_beat();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
